// File: rtl/cbadc_digital_modulator_pkg.sv
// Shared constants, fixed-point types and the saturating-add helper
// for the chain-of-integrators modulator.
package Cbadc_Mod_pkg;

  localparam int N          = 4;
  localparam int N_INT      = 4;
  localparam int N_MANT     = 12;
  localparam int BETA_SHIFT = 3;
  localparam int W          = 1 + N_INT + N_MANT;
  localparam int K          = 2 ** (N_MANT - BETA_SHIFT);
  localparam int STATE_MAX  = 2 ** (W - 1) - 1;
  localparam int STATE_MIN  = -(2 ** (W - 1));

  typedef logic signed [W-1:0] state_t;
  // Two guard bits: |x| + |d >>> BETA_SHIFT| + K cannot overflow W+2 bits.
  typedef logic signed [W+1:0] wide_t;

  typedef struct packed {
    logic   clamp;
    state_t val;
  } sat_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } mod_state_t;

  function automatic sat_t sat_add(wide_t sum);
    sat_t r;
    if (sum > wide_t'(STATE_MAX)) begin
      r.clamp = 1'b1;
      r.val   = state_t'(STATE_MAX);
    end else if (sum < wide_t'(STATE_MIN)) begin
      r.clamp = 1'b1;
      r.val   = state_t'(STATE_MIN);
    end else begin
      r.clamp = 1'b0;
      r.val   = sum[W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/cbadc_digital_modulator_int_stage.sv
// One integrator stage: owns its state register and its control bit,
// and reports whether the pending update would clamp.
module cbadc_int_stage
  import Cbadc_Mod_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic         step,
  output logic [W-1:0] x,
  output logic         s,
  output logic         clamp
);

  state_t xReg;
  logic   sReg;
  wide_t  sum;
  sat_t   satRes;

  // Control bit 1 means the integrator was non-negative, so feedback pulls down.
  always_comb begin
    sum    = wide_t'(xReg)
           + wide_t'(state_t'(d) >>> BETA_SHIFT)
           + (sReg ? -wide_t'(K) : wide_t'(K));
    satRes = sat_add(sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xReg <= '0;
      sReg <= 1'b0;
    end else if (step) begin
      xReg <= satRes.val;
      sReg <= ~satRes.val[W-1];
    end
  end

  assign x     = xReg;
  assign s     = sReg;
  assign clamp = satRes.clamp;

endmodule

// File: rtl/cbadc_digital_modulator.sv
// Bit-true digital control-bounded ADC front end: N chained integrators
// behind a one-deep valid/ready output register with a sticky overflow flag.
module cbadc_digital_modulator
  import Cbadc_Mod_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_u,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_sample,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ovf,
  input  logic         clr_ovf
);

  // Handshake: a word transfers on any edge where valid && ready; in_ready
  // is !out_valid || out_ready, so a consumed word is replaced with no bubble.
  mod_state_t   state;
  mod_state_t   stateNext;
  logic         step;
  logic [W-1:0] chain [N];
  logic [W-1:0] lastXUnused;
  logic [N-1:0] clampVec;
  logic         ovfReg;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign step      = in_valid && in_ready;

  assign chain[0] = in_u;

  // Every stage reads its predecessor's registered state, so all stages
  // advance from old values within one edge.
  for (genvar i = 0; i < N; i++) begin : gStage
    if (i < N - 1) begin : gMid
      cbadc_int_stage uStage (
        .clk   (clk),
        .rst   (rst),
        .d     (chain[i]),
        .step  (step),
        .x     (chain[i+1]),
        .s     (out_sample[i]),
        .clamp (clampVec[i])
      );
    end else begin : gLast
      cbadc_int_stage uStage (
        .clk   (clk),
        .rst   (rst),
        .d     (chain[i]),
        .step  (step),
        .x     (lastXUnused),
        .s     (out_sample[i]),
        .clamp (clampVec[i])
      );
    end
  end

  always_comb begin
    stateNext = state;
    if (step) begin
      stateNext = FULL;
    end else if (out_ready) begin
      stateNext = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // A clamp on this step takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovfReg <= 1'b0;
    end else if (step && (|clampVec)) begin
      ovfReg <= 1'b1;
    end else if (clr_ovf) begin
      ovfReg <= 1'b0;
    end
  end

  assign ovf = ovfReg;

endmodule

// File: tb/tb_cbadc_digital_modulator.sv
// Self-checking bench: independent integer model of the integrator chain
// feeding an expected-word queue, plus per-scenario directed checks.
module tb_cbadc_digital_modulator;

  localparam int N     = 4;
  localparam int W     = 17;
  localparam int K     = 512;
  localparam int SHIFT = 3;
  localparam int SMAX  = 65535;
  localparam int SMIN  = -65536;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_u;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_sample;
  logic         out_valid;
  logic         out_ready;
  logic         ovf;
  logic         clr_ovf;

  int compared   = 0;
  int mismatched = 0;

  logic [N-1:0] exp_q[$];
  int           xm[N];
  int           old_x[N];
  logic [N-1:0] sm;
  logic         ovf_m;
  logic [N-1:0] exp_word;
  logic         clamp_any;
  int           d_val;
  int           sum_val;

  always #5 clk = ~clk;

  cbadc_digital_modulator dut (
    .clk        (clk),
    .rst        (rst),
    .in_u       (in_u),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  // Scoreboard: sample mid-cycle, pop on transfer, model and push on step.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        for (int i = 0; i < N; i++) xm[i] = 0;
        sm    = '0;
        ovf_m = 1'b0;
      end else begin
        compared++;
        if (ovf !== ovf_m) begin
          mismatched++;
          $display("FAIL ovf_track: got %b want %b at %0t", ovf, ovf_m, $time);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL word_unexpected: got %h want none at %0t", out_sample, $time);
          end else begin
            exp_word = exp_q.pop_front();
            if (out_sample !== exp_word) begin
              mismatched++;
              $display("FAIL word: got %h want %h at %0t", out_sample, exp_word, $time);
            end
          end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
          for (int i = 0; i < N; i++) old_x[i] = xm[i];
          clamp_any = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (i == 0) d_val = int'($signed(in_u));
            else        d_val = old_x[i-1];
            sum_val = old_x[i] + (d_val >>> SHIFT) + (sm[i] ? -K : K);
            if (sum_val > SMAX) begin
              sum_val = SMAX;
              clamp_any = 1'b1;
            end else if (sum_val < SMIN) begin
              sum_val = SMIN;
              clamp_any = 1'b1;
            end
            xm[i] = sum_val;
            sm[i] = (sum_val >= 0);
          end
          exp_q.push_back(sm);
          if (clamp_any) ovf_m = 1'b1;
          else if (clr_ovf) ovf_m = 1'b0;
        end else if (clr_ovf) begin
          ovf_m = 1'b0;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; in_u = '0;
    repeat (3) cycle();
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++;
    if (ovf !== 1'b0) begin mismatched++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    compared++;
    if (out_sample !== 4'h0) begin mismatched++; $display("FAIL reset_out_sample: got %h want 0", out_sample); end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_zero_input();
    logic exp_bits[5];
    exp_bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    in_u = '0; in_valid = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cycle();
      compared++;
      if (out_sample[0] !== exp_bits[j]) begin
        mismatched++;
        $display("FAIL zero_s0[%0d]: got %b want %b", j, out_sample[0], exp_bits[j]);
      end
    end
    in_valid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_latency();
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();
    in_u = W'($urandom_range(0, 2 ** W - 1));
    in_valid = 1'b1;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL latency_pre: got %b want 0", out_valid); end
    cycle();
    in_valid = 1'b0;
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL latency_one_edge: got %b want 1", out_valid); end
    cycle();
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL latency_drain: got %b want 0", out_valid); end
    in_valid = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in_u = W'($urandom_range(0, 2 ** W - 1));
      cycle();
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL stream_gap[%0d]: got valid=%b ready=%b want 1/1", j, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] held;
    in_valid = 1'b1;
    out_ready = 1'b0;
    held = out_sample;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    for (int j = 0; j < 5; j++) begin
      in_u = W'($urandom_range(0, 2 ** W - 1));
      cycle();
      compared++;
      if (out_sample !== held || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got %h/%b want %h/0", j, out_sample, in_ready, held);
      end
    end
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_saturation();
    in_u = W'(SMAX); in_valid = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 2000; j++) begin
      clr_ovf = (j == 1000);
      cycle();
      if (j == 1000) begin
        compared++;
        if (ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
      end
    end
    clr_ovf = 1'b0;
    compared++;
    if (ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_sat: got %b want 1", ovf); end
    compared++;
    if (out_sample[0] !== 1'b1) begin mismatched++; $display("FAIL sat_s0: got %b want 1", out_sample[0]); end
    in_u = '0; in_valid = 1'b0; clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    compared++;
    if (ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    cycle();
  endtask

  task automatic test_async_reset();
    in_u = W'(SMAX); in_valid = 1'b1; out_ready = 1'b1;
    repeat (12) cycle();
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL async_out_valid: got %b want 0", out_valid); end
    compared++;
    if (ovf !== 1'b0) begin mismatched++; $display("FAIL async_ovf: got %b want 0", ovf); end
    compared++;
    if (out_sample !== 4'h0) begin mismatched++; $display("FAIL async_out_sample: got %h want 0", out_sample); end
    in_u = '0;
    cycle();
    rst = 1'b1;
    cycle();
    compared++;
    if (out_sample !== 4'hF) begin mismatched++; $display("FAIL cold_restart: got %h want f", out_sample); end
  endtask

  task automatic test_sine();
    real v;
    in_valid = 1'b1; out_ready = 1'b1; clr_ovf = 1'b0;
    for (int k = 0; k < 24000; k++) begin
      v = 2048.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0);
      in_u = W'($rtoi(v));
      cycle();
    end
    compared++;
    if (ovf !== 1'b0) begin mismatched++; $display("FAIL sine_no_ovf: got %b want 0", ovf); end
    in_valid = 1'b0;
    cycle();
    cycle();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_input();
    test_latency();
    test_backpressure();
    test_saturation();
    test_async_reset();
    test_sine();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
